expr_buffer: RTL
================

Name: expr_buffer

Overview:
- Token store directly downstream of the keyboard encoder; holds the expression being typed as 8-bit token codes.
- Level-held controls from the keyboard (insert, del, ptrLeft, ptrRight, eval) are edge-detected internally, so each press acts exactly once.
- Supports cursor-based insert, backspace-delete and cursor moves, and hands the expression to the evaluator.
- Read port serves the evaluator and the display.

Parameters:
- width, 8, token code width
- depth, 32, maximum number of tokens stored
- cw, $clog2(depth+1), width of count, cursor and rd_addr (derived; not overridden)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- dataIn  input  width  token code from keyboard; sampled on the rising edge of insert
- insert  input  1  level, high while a token key is held
- del  input  1  level, backspace
- ptrLeft  input  1  level, move cursor left
- ptrRight  input  1  level, move cursor right
- eval  input  1  level, start evaluation
- eval_done  input  1  one-cycle pulse from the evaluator; releases the lock
- rd_addr  input  cw  token index for the read port
- rd_data  output  width  mem[rd_addr], combinational; 0 when rd_addr >= count
- count  output  cw  number of valid tokens
- cursor  output  cw  insertion point, 0..count
- full  output  1  count == depth
- busy  output  1  a shift is in progress
- locked  output  1  evaluation in progress; editing is disabled
- eval_start  output  1  one-cycle pulse when evaluation begins
- err_full  output  1  one-cycle pulse when an insert is rejected because the buffer is full

Behaviour:
- Reset, asynchronous: count, cursor, all mem entries, eval_start, err_full, busy and locked go to 0; FSM goes to IDLE.
- Previous-level registers reset to 1, so a key held through reset release fires nothing.
- Edge detect: rise_x = x & ~prev_x; prev_x <= x every cycle in every state.
- In IDLE, only one rise is accepted per cycle, in priority eval > del > insert > ptrLeft > ptrRight. Other same-cycle rises are dropped, not queued.
- Rises in SHIFT_UP, SHIFT_DN or LOCKED are dropped.
- FSM states: IDLE, SHIFT_UP, SHIFT_DN, LOCKED.
- ptrLeft: cursor <= cursor-1 if cursor > 0, else no change (saturates). Single cycle.
- ptrRight: cursor <= cursor+1 if cursor < count, else no change. Single cycle.
- insert when full: nothing changes; err_full pulses in the next cycle.
- insert when not full: latch tok <= dataIn and set idx <= count.
  - If idx == cursor, go straight to the write step.
  - Otherwise go to SHIFT_UP, which moves one entry per cycle: mem[idx] <= mem[idx-1], idx--, until idx == cursor.
  - Write step: mem[cursor] <= tok, cursor++, count++, return to IDLE.
  - Latency from the rise to the updated count is (count - cursor) + 1 cycles.
- del when cursor == 0: no-op.
- del when cursor > 0: idx <= cursor-1; go to SHIFT_DN, which does mem[idx] <= mem[idx+1], idx++, until idx == count-1.
  - Final cycle: mem[count-1] <= 0, count--, cursor--, return to IDLE.
  - If cursor == count, only the final step runs (1 cycle).
- busy = (state == SHIFT_UP || state == SHIFT_DN).
- eval: eval_start pulses for 1 cycle; go to LOCKED with locked = 1. Contents and cursor are unchanged.
- LOCKED: eval_done returns the FSM to IDLE. eval_done in any other state is ignored.
- The evaluator reads tokens 0..count-1 through rd_addr while locked.
- Reset asserted mid-shift or while locked: immediate clear. No partial state survives.
- count and cursor never exceed depth. Empty is count == 0; del and ptr moves are no-ops when empty.

Decomposition:
- calc_pkg holds:
  - the shared token codes: digits 0x00-0x09, OP_ADD 0x1A, OP_SUB 0x1B, OP_MUL 0x1C, OP_DIV 0x1D, OP_LB 0x1E, OP_RB 0x1F, OP_DECIMAL 0xDD, OP_E 0xC0, OP_PI 0xC1, OP_EXP..OP_ATAN 0xF0-0xFC;
  - the expr_buffer FSM state enum.
- One sub-module, edge_rise: a per-signal rising-edge detector with an asynchronous active-low reset and a parameterised reset level. It is instantiated five times.

Test Plan:
- Type 1, 2, OP_ADD, 3 as separate held presses -> count = 4, cursor = 4, rd_data at addresses 0..3 is 0x01, 0x02, 0x1A, 0x03.
- From [1,2,+,3]: ptrLeft ×2, then insert 9 -> busy for 2 cycles; final contents [1,2,9,+,3], cursor = 3, count = 5.
- From [1,2,9,+,3] with cursor = 3: del -> [1,2,+,3], cursor = 2, count = 4, mem[4] = 0. With cursor = 0, del -> no change.
- Hold insert for 20 cycles, and raise insert and ptrLeft in the same cycle -> exactly one token stored and the cursor does not move left. ptrRight at cursor == count -> no change.
- Fill to depth 32 with insert as the 33rd press -> err_full pulses once; count stays 32 and full = 1.
- eval -> eval_start pulses once, locked = 1, and a following insert is ignored. eval_done -> locked = 0. Drive reset = 0 mid-SHIFT_UP -> count = 0 and cursor = 0 immediately.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: keyboard token codes and the expression
// buffer's FSM state encoding.
package calc_pkg;

   localparam logic [7:0] TOK_DIGIT_0 = 8'h00;
   localparam logic [7:0] TOK_DIGIT_9 = 8'h09;

   localparam logic [7:0] OP_ADD     = 8'h1A;
   localparam logic [7:0] OP_SUB     = 8'h1B;
   localparam logic [7:0] OP_MUL     = 8'h1C;
   localparam logic [7:0] OP_DIV     = 8'h1D;
   localparam logic [7:0] OP_LB      = 8'h1E;
   localparam logic [7:0] OP_RB      = 8'h1F;
   localparam logic [7:0] OP_DECIMAL = 8'hDD;
   localparam logic [7:0] OP_E       = 8'hC0;
   localparam logic [7:0] OP_PI      = 8'hC1;

   // Unary functions occupy the contiguous range 0xF0-0xFC.
   localparam logic [7:0] OP_EXP  = 8'hF0;
   localparam logic [7:0] OP_LN   = 8'hF1;
   localparam logic [7:0] OP_LOG  = 8'hF2;
   localparam logic [7:0] OP_SQRT = 8'hF3;
   localparam logic [7:0] OP_SQR  = 8'hF4;
   localparam logic [7:0] OP_INV  = 8'hF5;
   localparam logic [7:0] OP_POW  = 8'hF6;
   localparam logic [7:0] OP_SIN  = 8'hF7;
   localparam logic [7:0] OP_COS  = 8'hF8;
   localparam logic [7:0] OP_TAN  = 8'hF9;
   localparam logic [7:0] OP_ASIN = 8'hFA;
   localparam logic [7:0] OP_ACOS = 8'hFB;
   localparam logic [7:0] OP_ATAN = 8'hFC;

   typedef enum logic [1:0] {
      EB_IDLE     = 2'd0,
      EB_SHIFT_UP = 2'd1,
      EB_SHIFT_DN = 2'd2,
      EB_LOCKED   = 2'd3
   } eb_state_e;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a level-held key; the previous-level register
// resets to RST_LEVEL so a key held through reset release does not fire.
module edge_rise #(
   parameter logic RST_LEVEL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) prev_q <= RST_LEVEL;
      else         prev_q <= d_i;
   end

   assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/expr_buffer.sv
// Cursor-editable token store between the keyboard encoder and the evaluator.
// Inserts/deletes away from the end ripple one entry per cycle.
module expr_buffer
   import calc_pkg::*;
#(
   parameter int width = 8,
   parameter int depth = 32,
   parameter int cw    = $clog2(depth + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [width-1:0] dataIn,
   input  logic             insert,
   input  logic             del,
   input  logic             ptrLeft,
   input  logic             ptrRight,
   input  logic             eval,
   input  logic             eval_done,
   input  logic [cw-1:0]    rd_addr,
   output logic [width-1:0] rd_data,
   output logic [cw-1:0]    count,
   output logic [cw-1:0]    cursor,
   output logic             full,
   output logic             busy,
   output logic             locked,
   output logic             eval_start,
   output logic             err_full
);

   localparam int            aw      = (depth > 1) ? $clog2(depth) : 1;
   localparam logic [cw-1:0] ONE     = cw'(1);
   localparam logic [cw-1:0] DEPTH_C = cw'(depth);

   eb_state_e        state_q, state_d;
   logic [cw-1:0]    count_q, count_d;
   logic [cw-1:0]    cursor_q, cursor_d;
   logic [cw-1:0]    idx_q, idx_d;
   logic [width-1:0] tok_q, tok_d;
   logic [width-1:0] mem_q [depth];
   logic [width-1:0] mem_d [depth];
   logic             eval_start_q, eval_start_d;
   logic             err_full_q, err_full_d;

   logic rise_ins, rise_del, rise_left, rise_right, rise_eval;

   edge_rise #(.RST_LEVEL(1'b1)) u_rise_ins (
      .clk_i(clock), .rst_ni(reset), .d_i(insert),   .rise_o(rise_ins));
   edge_rise #(.RST_LEVEL(1'b1)) u_rise_del (
      .clk_i(clock), .rst_ni(reset), .d_i(del),      .rise_o(rise_del));
   edge_rise #(.RST_LEVEL(1'b1)) u_rise_left (
      .clk_i(clock), .rst_ni(reset), .d_i(ptrLeft),  .rise_o(rise_left));
   edge_rise #(.RST_LEVEL(1'b1)) u_rise_right (
      .clk_i(clock), .rst_ni(reset), .d_i(ptrRight), .rise_o(rise_right));
   edge_rise #(.RST_LEVEL(1'b1)) u_rise_eval (
      .clk_i(clock), .rst_ni(reset), .d_i(eval),     .rise_o(rise_eval));

   logic [cw-1:0] idx_m1, idx_p1, cnt_m1, cur_m1, cur_p1, cnt_p1;

   assign idx_m1 = idx_q - ONE;
   assign idx_p1 = idx_q + ONE;
   assign cnt_m1 = count_q - ONE;
   assign cnt_p1 = count_q + ONE;
   assign cur_m1 = cursor_q - ONE;
   assign cur_p1 = cursor_q + ONE;

   assign full       = (count_q == DEPTH_C);
   assign busy       = (state_q == EB_SHIFT_UP) || (state_q == EB_SHIFT_DN);
   assign locked     = (state_q == EB_LOCKED);
   assign eval_start = eval_start_q;
   assign err_full   = err_full_q;
   assign count      = count_q;
   assign cursor     = cursor_q;
   assign rd_data    = (rd_addr < count_q) ? mem_q[rd_addr[aw-1:0]] : '0;

   // The last shift cycle also performs the write/trim, so the edit lands
   // (count - cursor) cycles after the rise is taken.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      cursor_d     = cursor_q;
      idx_d        = idx_q;
      tok_d        = tok_q;
      mem_d        = mem_q;
      eval_start_d = 1'b0;
      err_full_d   = 1'b0;
      case (state_q)
         EB_IDLE: begin
            if (rise_eval) begin
               eval_start_d = 1'b1;
               state_d      = EB_LOCKED;
            end else if (rise_del) begin
               if (cursor_q != '0) begin
                  if (cursor_q == count_q) begin
                     mem_d[cnt_m1[aw-1:0]] = '0;
                     count_d               = cnt_m1;
                     cursor_d              = cur_m1;
                  end else begin
                     idx_d   = cur_m1;
                     state_d = EB_SHIFT_DN;
                  end
               end
            end else if (rise_ins) begin
               if (full) begin
                  err_full_d = 1'b1;
               end else if (cursor_q == count_q) begin
                  mem_d[cursor_q[aw-1:0]] = dataIn;
                  count_d                 = cnt_p1;
                  cursor_d                = cur_p1;
               end else begin
                  tok_d   = dataIn;
                  idx_d   = count_q;
                  state_d = EB_SHIFT_UP;
               end
            end else if (rise_left) begin
               if (cursor_q != '0) cursor_d = cur_m1;
            end else if (rise_right) begin
               if (cursor_q < count_q) cursor_d = cur_p1;
            end
         end
         EB_SHIFT_UP: begin
            mem_d[idx_q[aw-1:0]] = mem_q[idx_m1[aw-1:0]];
            idx_d                = idx_m1;
            if (idx_m1 == cursor_q) begin
               mem_d[cursor_q[aw-1:0]] = tok_q;
               count_d                 = cnt_p1;
               cursor_d                = cur_p1;
               state_d                 = EB_IDLE;
            end
         end
         EB_SHIFT_DN: begin
            mem_d[idx_q[aw-1:0]] = mem_q[idx_p1[aw-1:0]];
            idx_d                = idx_p1;
            if (idx_p1 == cnt_m1) begin
               mem_d[cnt_m1[aw-1:0]] = '0;
               count_d               = cnt_m1;
               cursor_d              = cur_m1;
               state_d               = EB_IDLE;
            end
         end
         EB_LOCKED: begin
            if (eval_done) state_d = EB_IDLE;
         end
         default: state_d = EB_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= EB_IDLE;
         count_q      <= '0;
         cursor_q     <= '0;
         idx_q        <= '0;
         tok_q        <= '0;
         mem_q        <= '{default: '0};
         eval_start_q <= 1'b0;
         err_full_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         cursor_q     <= cursor_d;
         idx_q        <= idx_d;
         tok_q        <= tok_d;
         mem_q        <= mem_d;
         eval_start_q <= eval_start_d;
         err_full_q   <= err_full_d;
      end
   end

endmodule
